// File: rtl/chunked_adder.sv
// Multi-cycle adder: sums WIDTH-bit operands CHUNK bits per cycle behind a valid/ready handshake.
// Optional signed-overflow output enabled by defining CHUNKED_ADDER_OVF_EN.
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CHUNKED_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [KW-1:0]    k;
    logic [CHUNK:0]   chunk_sum;
    logic             last;

    always_comb begin
        chunk_sum = {1'b0, a_q[k*CHUNK +: CHUNK]} + {1'b0, b_q[k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        last      = (k == KW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= cin;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry                 <= chunk_sum[CHUNK];
                    k                     <= k + KW'(1);
                    if (last) begin
                        cout      <= chunk_sum[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
                        // carry into MSB recovered as a^b^sum at the MSB
                        ovf       <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_sum[CHUNK-1]
                                   ^ chunk_sum[CHUNK];
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: three instances (CHUNK=2, 8, 1) share stimulus and are
// compared against plain-arithmetic expectations; define CHUNKED_ADDER_OVF_EN to cover ovf.
module tb_chunked_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a, b;
    logic       cin;
    logic [2:0] in_ready, out_valid, cout;
    logic [7:0] sum [3];
`ifdef CHUNKED_ADDER_OVF_EN
    logic [2:0] ovf;
`endif

    int checks = 0;
    int errors = 0;
    int lat [3] = '{4, 1, 8};

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid[0]), .out_ready(out_ready),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(ovf[0]),
`endif
        .sum(sum[0]), .cout(cout[0]));

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid[1]), .out_ready(out_ready),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(ovf[1]),
`endif
        .sum(sum[1]), .cout(cout[1]));

    chunked_adder #(.WIDTH(8), .CHUNK(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid[2]), .out_ready(out_ready),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(ovf[2]),
`endif
        .sum(sum[2]), .cout(cout[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on all three instances; optional stall and operand disturbance.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input int stall, input bit disturb, input string name);
        logic [8:0] full;
        logic       exp_ovf;
        full    = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
        exp_ovf = (ta[7] == tb_[7]) && (full[7] != ta[7]);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        for (int d = 0; d < 3; d++)
            chk($sformatf("%s in_ready_idle d%0d", name, d), {31'd0, in_ready[d]}, 32'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (disturb) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s out_valid c%0d d%0d", name, c, d),
                    {31'd0, out_valid[d]}, {31'd0, c >= lat[d]});
                chk($sformatf("%s in_ready_busy c%0d d%0d", name, c, d),
                    {31'd0, in_ready[d]}, 32'd0);
            end
        end
        in_valid = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) tick();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s sum s%0d d%0d", name, s, d), {24'd0, sum[d]}, {24'd0, full[7:0]});
                chk($sformatf("%s cout s%0d d%0d", name, s, d), {31'd0, cout[d]}, {31'd0, full[8]});
                chk($sformatf("%s held s%0d d%0d", name, s, d), {30'd0, out_valid[d], in_ready[d]}, 32'd2);
`ifdef CHUNKED_ADDER_OVF_EN
                chk($sformatf("%s ovf s%0d d%0d", name, s, d), {31'd0, ovf[d]}, {31'd0, exp_ovf});
`endif
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int d = 0; d < 3; d++)
            chk($sformatf("%s after_ack d%0d", name, d), {30'd0, out_valid[d], in_ready[d]}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset sum d%0d", d), {24'd0, sum[d]}, 32'd0);
            chk($sformatf("reset flags d%0d", d), {29'd0, out_valid[d], cout[d], in_ready[d]}, 32'd1);
        end
        rst_n = 1'b1;
        tick();

        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, "ff_plus_1");
        run_op(8'h5A, 8'h3C, 1'b1, 5, 1'b0, "stall5");
        run_op(8'hFF, 8'hFF, 1'b1, 1, 1'b0, "all_ones");
        run_op(8'h00, 8'h00, 1'b0, 0, 1'b0, "zeros");

        // Abort mid-operation with reset; no result may appear afterwards.
        a = 8'hC3; b = 8'h77; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("abort_reset d%0d", d),
                {22'd0, sum[d], out_valid[d], cout[d], in_ready[d]}, 32'd1);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            for (int d = 0; d < 3; d++)
                chk($sformatf("abort_quiet c%0d d%0d", c, d), {30'd0, out_valid[d], in_ready[d]}, 32'd1);
        end
        run_op(8'h10, 8'h20, 1'b0, 0, 1'b0, "post_reset");

        run_op(8'hA5, 8'h6B, 1'b1, 2, 1'b1, "disturb");

`ifdef CHUNKED_ADDER_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, "ovf_pos");
        run_op(8'h80, 8'hFF, 1'b0, 0, 1'b0, "ovf_neg");
`endif

        for (int i = 0; i < 300; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                   1'($urandom), $sformatf("rand%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
